port_pattern_seq: RTL and testbench

//  Bus-master sequencer that replays a stored byte pattern into one register of a Krake I/O port
//  (normally the port data register), one entry per step, at a programmable step interval.

---
 rtl/port_pattern_seq.sv | 143 ++++++++++++++
 tb/tb_port_pattern_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/port_pattern_seq.sv
// port_pattern_seq: replays a stored byte pattern into one I/O-port register at a programmable step interval
module port_pattern_seq #(
    parameter int         DEPTH   = 16,
    parameter int         DIV_W   = 16,
    parameter logic [3:0] TGT_ADR = 4'h0,
    parameter int         TIMEOUT = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       stb_i,
    input  logic       we_i,
    input  logic [3:0] adr_i,
    input  logic [7:0] dat_i,
    output logic [7:0] dat_o,
    output logic       ack_o,
    output logic       m_stb_o,
    output logic       m_we_o,
    output logic [3:0] m_adr_o,
    output logic [7:0] m_dat_o,
    input  logic       m_ack_i,
    output logic       busy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [15:0] DMASK = 16'((32'd1 << DIV_W) - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, GAP} state_t;

    state_t         state, state_d;
    logic [7:0]     ram [DEPTH];
    logic           run, loop, done, err;
    logic [LW-1:0]  len;
    logic [15:0]    div;
    logic [AW-1:0]  wptr, idx, idx_nxt, issue_idx;
    logic [DIV_W-1:0] cnt;
    logic [TW-1:0]  to_cnt;
    logic           busy, ctrl_wr, cfg_wr, eff_run, eff_loop, last, issue, fin_done, fin_err, start;
    logic [7:0]     rd;

    assign busy      = state != IDLE;
    assign busy_o    = busy;
    assign m_we_o    = m_stb_o;
    assign m_adr_o   = TGT_ADR;
    assign ctrl_wr   = stb_i & we_i & (adr_i == 4'd0);
    assign cfg_wr    = stb_i & we_i & ~busy;
    assign eff_run   = ctrl_wr ? dat_i[0] : run;
    assign eff_loop  = ctrl_wr ? dat_i[1] : loop;
    assign last      = {1'b0, idx} == len - 1'b1;
    assign idx_nxt   = last ? '0 : idx + 1'b1;
    assign issue_idx = state == GAP ? idx_nxt : idx;
    assign start     = state == IDLE && ctrl_wr && dat_i[0] && len != 0;

    always_comb begin
        state_d  = state;
        issue    = 1'b0;
        fin_done = 1'b0;
        fin_err  = 1'b0;
        case (state)
            IDLE: state_d = start ? ISSUE : IDLE;
            ISSUE: begin
                issue   = eff_run;
                state_d = eff_run ? WAIT_ACK : IDLE;
            end
            WAIT_ACK: begin
                fin_err = !m_ack_i && to_cnt == TW'(TIMEOUT - 1);
                state_d = m_ack_i ? (eff_run ? GAP : IDLE) : fin_err ? IDLE : WAIT_ACK;
            end
            default: begin
                fin_done = eff_run && cnt == 0 && last && !eff_loop;
                issue    = eff_run && cnt == 0 && !fin_done;
                state_d  = !eff_run || fin_done ? IDLE : issue ? WAIT_ACK : GAP;
            end
        endcase
    end

    always_comb begin
        rd = adr_i == 4'd0 ? {3'b0, err, done, busy, loop, run} :
             adr_i == 4'd1 ? 8'(len) :
             adr_i == 4'd2 ? div[7:0] :
             adr_i == 4'd3 ? div[15:8] :
             adr_i == 4'd4 ? 8'(wptr) :
             adr_i == 4'd5 ? ram[wptr] : 8'h00;
    end

    always_ff @(posedge clk_i)
        if (cfg_wr && adr_i == 4'd5)
            ram[wptr] <= dat_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            {run, loop, done, err} <= '0;
            len     <= '0;
            div     <= '0;
            wptr    <= '0;
            idx     <= '0;
            cnt     <= '0;
            to_cnt  <= '0;
            m_stb_o <= 1'b0;
            m_dat_o <= '0;
            ack_o   <= 1'b0;
            dat_o   <= '0;
        end else begin
            state <= state_d;
            ack_o <= stb_i;
            dat_o <= stb_i ? rd : 8'h00;
            // host CTRL write overrides any internal RUN clear in the same cycle
            if (ctrl_wr)
                {loop, run} <= dat_i[1:0];
            else if (fin_done || fin_err || (state == IDLE && run))
                run <= 1'b0;
            if (start)
                {done, err, idx} <= '0;
            if (fin_done || (state == IDLE && run && !ctrl_wr && len == 0))
                done <= 1'b1;
            if (fin_err)
                err <= 1'b1;
            if (cfg_wr && adr_i == 4'd1)
                len <= 32'(dat_i) > DEPTH ? LW'(DEPTH) : dat_i[AW:0];
            if (cfg_wr && adr_i == 4'd2)
                div[7:0] <= dat_i & DMASK[7:0];
            if (cfg_wr && adr_i == 4'd3)
                div[15:8] <= dat_i & DMASK[15:8];
            if (cfg_wr && adr_i == 4'd4)
                wptr <= dat_i[AW-1:0];
            else if (cfg_wr && adr_i == 4'd5)
                wptr <= wptr + 1'b1;
            if (issue) begin
                m_stb_o <= 1'b1;
                m_dat_o <= ram[issue_idx];
                idx     <= issue_idx;
                to_cnt  <= '0;
            end else if (state == WAIT_ACK) begin
                if (m_ack_i || fin_err)
                    m_stb_o <= 1'b0;
                to_cnt <= to_cnt + 1'b1;
                cnt    <= div[DIV_W-1:0];
            end else if (state == GAP && cnt != 0)
                cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_port_pattern_seq.sv
// tb_port_pattern_seq: directed checks of the pattern sequencer against an acking port model
module tb_port_pattern_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stb = 1'b0;
    logic       we = 1'b0;
    logic [3:0] adr = '0;
    logic [7:0] dat = '0;
    logic [7:0] rdat;
    logic       ack;
    logic       m_stb, m_we, m_ack;
    logic [3:0] m_adr;
    logic [7:0] m_dat;
    logic       busy;
    logic       ack_en = 1'b1;
    logic       stb_prev = 1'b0;
    int         cyc = 0;
    int         stb_hi = 0;
    int         adr_bad = 0;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] log_dat [$];
    int         log_cyc [$];

    port_pattern_seq dut (
        .clk_i(clk), .rst_i(rst), .stb_i(stb), .we_i(we), .adr_i(adr), .dat_i(dat),
        .dat_o(rdat), .ack_o(ack), .m_stb_o(m_stb), .m_we_o(m_we), .m_adr_o(m_adr),
        .m_dat_o(m_dat), .m_ack_i(m_ack), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // port model: acks one cycle after seeing a strobe, logs each new transfer
    always @(posedge clk) begin
        cyc <= cyc + 1;
        m_ack <= rst ? 1'b0 : ack_en & m_stb & ~m_ack;
        if (m_stb)
            stb_hi <= stb_hi + 1;
        if (m_stb && !stb_prev) begin
            log_dat.push_back(m_dat);
            log_cyc.push_back(cyc);
            if (m_adr != 4'h0 || !m_we)
                adr_bad <= adr_bad + 1;
        end
        stb_prev <= m_stb;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        stb = 1'b1; we = 1'b1; adr = a; dat = d;
        @(negedge clk);
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        @(negedge clk);
        stb = 1'b1; we = 1'b0; adr = a;
        @(negedge clk);
        chk({tag, "_ack"}, 32'(ack), 1);
        chk(tag, 32'(rdat), 32'(exp));
        stb = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int k = 0;
        while (busy && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(busy), 0);
    endtask

    task automatic wait_rises(input string tag, input int n, input int lim);
        int k = 0;
        while (log_dat.size() < n && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(log_dat.size() >= n), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [7:0] pat [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
        int n0, n1, h0, k;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_dat", 32'(rdat), 0);
        chk("rst_mstb", 32'(m_stb), 0);
        chk("rst_mwe", 32'(m_we), 0);
        chk("rst_madr", 32'(m_adr), 0);
        chk("rst_mdat", 32'(m_dat), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        rd_chk("rst_ctrl", 4'd0, 8'h00);
        rd_chk("rst_len", 4'd1, 8'h00);

        // single pass, DIV=0
        wr(4'd1, 8'd4);
        wr(4'd4, 8'd0);
        for (int i = 0; i < 4; i++) wr(4'd5, pat[i]);
        wr(4'd2, 8'd0);
        wr(4'd3, 8'd0);
        n0 = log_dat.size();
        wr(4'd0, 8'h01);
        chk("t1_busy", 32'(busy), 1);
        wait_idle("t1_idle", 100);
        chk("t1_count", log_dat.size() - n0, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("t1_dat%0d", i), 32'(log_dat[n0+i]), 32'(pat[i]));
        for (int i = 1; i < 4; i++) chk($sformatf("t1_per%0d", i), log_cyc[n0+i] - log_cyc[n0+i-1], 3);
        rd_chk("t1_ctrl", 4'd0, 8'h08);

        // loop mode, DIV=5, config writes while busy are ignored, stop mid-gap
        wr(4'd2, 8'd5);
        n0 = log_dat.size();
        wr(4'd0, 8'h03);
        wait_rises("t2_first", n0 + 1, 50);
        wr(4'd1, 8'd2);
        wr(4'd4, 8'd9);
        wr(4'd5, 8'h55);
        rd_chk("t5_len_busy", 4'd1, 8'd4);
        rd_chk("t5_wptr_busy", 4'd4, 8'd4);
        wait_rises("t2_six", n0 + 6, 200);
        for (int i = 0; i < 6; i++) chk($sformatf("t2_dat%0d", i), 32'(log_dat[n0+i]), 32'(pat[i%4]));
        for (int i = 1; i < 6; i++) chk($sformatf("t2_per%0d", i), log_cyc[n0+i] - log_cyc[n0+i-1], 8);
        k = 0;
        while (m_stb && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t2_stb_low", 32'(m_stb), 0);
        wr(4'd0, 8'h00);
        chk("t2_stop_busy", 32'(busy), 0);
        n1 = log_dat.size();
        repeat (30) @(negedge clk);
        chk("t2_no_more", log_dat.size() - n1, 0);
        rd_chk("t2_ctrl", 4'd0, 8'h00);

        // timeout: port never acks
        ack_en = 1'b0;
        h0 = stb_hi;
        n0 = log_dat.size();
        wr(4'd0, 8'h01);
        wait_idle("t3_idle", 100);
        chk("t3_stb_cycles", stb_hi - h0, 15);
        chk("t3_count", log_dat.size() - n0, 1);
        rd_chk("t3_ctrl", 4'd0, 8'h10);

        // reset mid WAIT_ACK
        wr(4'd0, 8'h01);
        repeat (4) @(negedge clk);
        chk("t5_pre_stb", 32'(m_stb), 1);
        chk("t5_pre_busy", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_mstb", 32'(m_stb), 0);
        chk("t5_mwe", 32'(m_we), 0);
        chk("t5_mdat", 32'(m_dat), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_ack", 32'(ack), 0);
        chk("t5_dat", 32'(rdat), 0);
        rst = 1'b0;
        ack_en = 1'b1;
        rd_chk("t5_ctrl", 4'd0, 8'h00);
        rd_chk("t5_len", 4'd1, 8'h00);
        rd_chk("t5_div", 4'd2, 8'h00);

        // RUN with LEN=0
        h0 = stb_hi;
        wr(4'd0, 8'h01);
        repeat (3) @(negedge clk);
        rd_chk("t6_ctrl", 4'd0, 8'h08);
        chk("t6_no_stb", stb_hi - h0, 0);
        chk("t6_busy", 32'(busy), 0);

        // write pointer wrap, LEN clamp, unmapped read
        wr(4'd4, 8'd15);
        wr(4'd5, 8'hAA);
        wr(4'd5, 8'hBB);
        rd_chk("t4_wptr", 4'd4, 8'd1);
        wr(4'd4, 8'd15);
        rd_chk("t4_ram15", 4'd5, 8'hAA);
        wr(4'd4, 8'd0);
        rd_chk("t4_ram0", 4'd5, 8'hBB);
        wr(4'd1, 8'h20);
        rd_chk("t4_len_clamp", 4'd1, 8'd16);
        wr(4'd1, 8'd5);
        rd_chk("t4_len5", 4'd1, 8'd5);
        rd_chk("t4_unmapped", 4'd7, 8'h00);
        chk("m_adr_we", adr_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
